yarvi_lsq: RTL and testbench

// - Load/store request queue between yarvi_ex (producer of ex_mem_* requests) and yarvi_me (consumer).
// - Decouples ex from me backpressure (me_ready).
// - Rejects misaligned accesses.
// - Keeps a per-register scoreboard of loads whose data has not yet returned, so ex/rf can interlock on rd.

---
 rtl/yarvi_lsq_pkg.sv | 39 +++
 rtl/yarvi_lsq_if.sv | 54 +++++
 rtl/yarvi_lsq_fifo.sv | 71 +++++++
 rtl/yarvi_lsq.sv | 119 +++++++++++
 tb/tb_yarvi_lsq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/yarvi_lsq_pkg.sv
// yarvi_lsq_pkg
// Purpose : Shared widths, the packed request-entry layout and the
//           alignment helper used by the load/store queue.
// Contents: VMSB / XMSB address and data MSBs, LSQ_DEPTH_LG2 default depth,
//           lsq_entry_t (we, addr, wdata, sizelg2, tag, sext),
//           is_misaligned() helper.
package yarvi_lsq_pkg;

    localparam int VMSB          = 31;
    localparam int XMSB          = 63;
    localparam int LSQ_DEPTH_LG2 = 2;

    typedef struct packed {
        logic            we;
        logic [VMSB:0]   addr;
        logic [XMSB:0]   wdata;
        logic [1:0]      sizelg2;
        logic [4:0]      tag;
        logic            sext;
    } lsq_entry_t;

    localparam int ENTRY_W = $bits(lsq_entry_t);

    // A byte access can never be misaligned; wider accesses need their low
    // sizelg2 address bits clear.
    function automatic logic is_misaligned(input logic [VMSB:0] addr,
                                           input logic [1:0]    sizelg2);
        logic r;
        case (sizelg2)
            2'd0:    r = 1'b0;
            2'd1:    r = addr[0];
            2'd2:    r = (addr[1:0] != 2'b00);
            2'd3:    r = (addr[2:0] != 3'b000);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/yarvi_lsq_if.sv
// yarvi_lsq_if
// Purpose : Bundles every non-clock signal of the load/store queue.
// Modports: slave  - the queue itself (yarvi_lsq).
//           master - the environment (ex producer, me consumer, interlock).
// Groups  : in_*  request from ex, out_* head entry to me,
//           me_readdata* load return, load_pending / misaligned* / empty status.
interface yarvi_lsq_if;
    import yarvi_lsq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            in_writeenable;
    logic [VMSB:0]   in_address;
    logic [XMSB:0]   in_writedata;
    logic [1:0]      in_sizelg2;
    logic [4:0]      in_readtag;
    logic            in_readsignextend;

    logic            out_valid;
    logic            out_ready;
    logic            out_writeenable;
    logic [VMSB:0]   out_address;
    logic [XMSB:0]   out_writedata;
    logic [1:0]      out_sizelg2;
    logic [4:0]      out_readtag;
    logic            out_readsignextend;

    logic            me_readdatavalid;
    logic [4:0]      me_readdatatag;

    logic [31:0]     load_pending;
    logic            misaligned;
    logic [VMSB:0]   misaligned_addr;
    logic            empty;

    modport slave (
        input  in_valid, in_writeenable, in_address, in_writedata,
               in_sizelg2, in_readtag, in_readsignextend,
               out_ready, me_readdatavalid, me_readdatatag,
        output in_ready, out_valid, out_writeenable, out_address, out_writedata,
               out_sizelg2, out_readtag, out_readsignextend,
               load_pending, misaligned, misaligned_addr, empty
    );

    modport master (
        output in_valid, in_writeenable, in_address, in_writedata,
               in_sizelg2, in_readtag, in_readsignextend,
               out_ready, me_readdatavalid, me_readdatatag,
        input  in_ready, out_valid, out_writeenable, out_address, out_writedata,
               out_sizelg2, out_readtag, out_readsignextend,
               load_pending, misaligned, misaligned_addr, empty
    );

endinterface

// File: rtl/yarvi_lsq_fifo.sv
// yarvi_lsq_fifo
// Purpose : Generic synchronous FIFO with occupancy count, 1<<DEPTH_LG2 entries.
// Ports   : clock, reset_n (sync, active-low)
//           i_push / i_wdata  - write (caller guarantees !o_full)
//           i_pop             - read advance (caller guarantees !o_empty)
//           o_rdata           - head entry, combinational from storage
//           o_full / o_empty  - occupancy flags derived from the count
module yarvi_lsq_fifo #(
    parameter int DEPTH_LG2 = 2,
    parameter int WIDTH     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                   DEPTH    = 1 << DEPTH_LG2;
    localparam logic [DEPTH_LG2-1:0] PTR_ONE  = DEPTH_LG2'(1);
    localparam logic [DEPTH_LG2:0]   CNT_ONE  = (DEPTH_LG2 + 1)'(1);
    localparam logic [DEPTH_LG2:0]   CNT_FULL = (DEPTH_LG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LG2-1:0] r_head;
    logic [DEPTH_LG2-1:0] r_tail;
    logic [DEPTH_LG2:0]   r_count;
    logic [DEPTH_LG2:0]   w_count_next;

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer and count registers; pointers wrap silently at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (i_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage; contents are meaningless until the count covers them.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/yarvi_lsq.sv
// yarvi_lsq
// Purpose : Load/store request queue between ex and me. Decouples ex from
//           me backpressure, rejects misaligned accesses and tracks loads
//           whose data has not yet returned so ex/rf can interlock on rd.
// Ports   : clock, reset_n (sync, active-low)
//           bus (yarvi_lsq_if.slave): in_* request, out_* head entry,
//           me_readdata* load return, load_pending / misaligned /
//           misaligned_addr / empty status.
module yarvi_lsq
    import yarvi_lsq_pkg::*;
#(
    parameter int DEPTH_LG2 = LSQ_DEPTH_LG2
) (
    input  logic         clock,
    input  logic         reset_n,
    yarvi_lsq_if.slave   bus
);

    lsq_entry_t          w_entry_in;
    lsq_entry_t          w_entry_out;
    logic [ENTRY_W-1:0]  w_rdata;
    logic                w_full;
    logic                w_empty;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_mis_in;
    logic                w_acc;
    logic                w_rej;
    logic                w_deq;
    logic [31:0]         w_set_mask;
    logic [31:0]         w_clr_mask;
    logic [31:0]         w_pend_next;

    logic [31:0]         r_load_pending;
    logic                r_misaligned;
    logic [VMSB:0]       r_misaligned_addr;

    assign w_entry_in = '{
        we:      bus.in_writeenable,
        addr:    bus.in_address,
        wdata:   bus.in_writedata,
        sizelg2: bus.in_sizelg2,
        tag:     bus.in_readtag,
        sext:    bus.in_readsignextend
    };

    // in_ready looks only at occupancy, never at out_ready, so a full queue
    // opens up one cycle after a dequeue.
    assign w_in_ready  = !w_full;
    assign w_out_valid = !w_empty;
    assign w_mis_in    = is_misaligned(bus.in_address, bus.in_sizelg2);
    assign w_acc       = bus.in_valid & w_in_ready & !w_mis_in;
    assign w_rej       = bus.in_valid & w_in_ready & w_mis_in;
    assign w_deq       = w_out_valid & bus.out_ready;

    yarvi_lsq_fifo #(
        .DEPTH_LG2 (DEPTH_LG2),
        .WIDTH     (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_acc),
        .i_wdata (w_entry_in),
        .i_pop   (w_deq),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_entry_out = lsq_entry_t'(w_rdata);

    // Scoreboard update: set is applied after clear so a younger load to the
    // same rd stays pending; x0 is never tracked.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (w_acc && !bus.in_writeenable && (bus.in_readtag != 5'd0)) begin
            w_set_mask[bus.in_readtag] = 1'b1;
        end else begin
            w_set_mask = 32'd0;
        end
        if (bus.me_readdatavalid) begin
            w_clr_mask[bus.me_readdatatag] = 1'b1;
        end else begin
            w_clr_mask = 32'd0;
        end
        w_pend_next    = (r_load_pending & ~w_clr_mask) | w_set_mask;
        w_pend_next[0] = 1'b0;
    end

    // Scoreboard and misalignment report registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_load_pending    <= 32'd0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
        end else begin
            r_load_pending <= w_pend_next;
            r_misaligned   <= w_rej;
            if (w_rej) begin
                r_misaligned_addr <= bus.in_address;
            end
        end
    end

    assign bus.in_ready           = w_in_ready;
    assign bus.out_valid          = w_out_valid;
    assign bus.out_writeenable    = w_entry_out.we;
    assign bus.out_address        = w_entry_out.addr;
    assign bus.out_writedata      = w_entry_out.wdata;
    assign bus.out_sizelg2        = w_entry_out.sizelg2;
    assign bus.out_readtag        = w_entry_out.tag;
    assign bus.out_readsignextend = w_entry_out.sext;
    assign bus.load_pending       = r_load_pending;
    assign bus.misaligned         = r_misaligned;
    assign bus.misaligned_addr    = r_misaligned_addr;
    assign bus.empty              = w_empty;

endmodule

// File: tb/tb_yarvi_lsq.sv
// tb_yarvi_lsq
// Directed self-checking bench for yarvi_lsq (DEPTH = 4).
module tb_yarvi_lsq;

    logic clock;
    logic reset_n;
    int   n_total;
    int   n_pass;

    yarvi_lsq_if bus ();

    yarvi_lsq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [1:0] sz, input logic [4:0] tag);
        bus.in_valid          = 1'b1;
        bus.in_writeenable    = we;
        bus.in_address        = addr;
        bus.in_writedata      = wd;
        bus.in_sizelg2        = sz;
        bus.in_readtag        = tag;
        bus.in_readsignextend = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!bus.empty) tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", bus.empty, 1'b1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_writeenable = 1'b0;
        bus.in_address = 32'd0;
        bus.in_writedata = 64'd0;
        bus.in_sizelg2 = 2'd0;
        bus.in_readtag = 5'd0;
        bus.in_readsignextend = 1'b0;
        bus.out_ready = 1'b0;
        bus.me_readdatavalid = 1'b0;
        bus.me_readdatatag = 5'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset / idle
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_pending", bus.load_pending, 64'd0);
        chk("rst_misaligned", bus.misaligned, 1'b0);

        // Load x5 at 0x100, size D
        req(1'b0, 32'h100, 64'd0, 2'd3, 5'd5);
        tick();
        bus.in_valid = 1'b0;
        chk("ld5_out_valid", bus.out_valid, 1'b1);
        chk("ld5_out_addr", bus.out_address, 64'h100);
        chk("ld5_out_tag", bus.out_readtag, 64'd5);
        chk("ld5_pending", bus.load_pending, 64'h20);
        bus.me_readdatavalid = 1'b1;
        bus.me_readdatatag = 5'd5;
        tick();
        bus.me_readdatavalid = 1'b0;
        chk("ld5_cleared", bus.load_pending, 64'd0);
        drain();

        // Five back-to-back stores into a 4-deep queue with out_ready low
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 32'(i * 8), 64'(32'hA0 + i), 2'd3, 5'd0);
            chk("st_in_ready", bus.in_ready, 1'b1);
            tick();
        end
        req(1'b1, 32'h20, 64'hA4, 2'd3, 5'd0);
        chk("full_in_ready", bus.in_ready, 1'b0);
        tick();
        chk("full_held", bus.in_ready, 1'b0);
        chk("full_head", bus.out_address, 64'h0);
        chk("full_head_wd", bus.out_writedata, 64'hA0);
        bus.out_ready = 1'b1;
        tick();
        chk("deq1_addr", bus.out_address, 64'h8);
        chk("deq1_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("deq2_addr", bus.out_address, 64'h10);
        chk("deq2_wd", bus.out_writedata, 64'hA2);
        tick();
        chk("deq3_addr", bus.out_address, 64'h18);
        tick();
        chk("deq4_addr", bus.out_address, 64'h20);
        chk("deq4_wd", bus.out_writedata, 64'hA4);
        tick();
        chk("stores_empty", bus.empty, 1'b1);
        bus.out_ready = 1'b0;

        // Misaligned word load at 0x102
        req(1'b0, 32'h102, 64'd0, 2'd2, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        chk("mis_flag", bus.misaligned, 1'b1);
        chk("mis_addr", bus.misaligned_addr, 64'h102);
        chk("mis_empty", bus.empty, 1'b1);
        chk("mis_pending", bus.load_pending, 64'd0);
        tick();
        chk("mis_pulse_end", bus.misaligned, 1'b0);
        chk("mis_addr_hold", bus.misaligned_addr, 64'h102);

        // Halfword at 0x102 is aligned
        req(1'b0, 32'h102, 64'd0, 2'd1, 5'd4);
        tick();
        bus.in_valid = 1'b0;
        chk("half_empty", bus.empty, 1'b0);
        chk("half_mis", bus.misaligned, 1'b0);
        chk("half_pending", bus.load_pending, 64'h10);

        // Same-cycle set and clear of tag 7
        req(1'b0, 32'h200, 64'd0, 2'd2, 5'd7);
        tick();
        chk("t7_set", bus.load_pending, 64'h90);
        bus.me_readdatavalid = 1'b1;
        bus.me_readdatatag = 5'd7;
        tick();
        bus.in_valid = 1'b0;
        chk("t7_set_wins", bus.load_pending, 64'h90);
        tick();
        chk("t7_clear", bus.load_pending, 64'h10);
        bus.me_readdatatag = 5'd9;
        tick();
        chk("t9_ignored", bus.load_pending, 64'h10);
        bus.me_readdatatag = 5'd4;
        tick();
        bus.me_readdatavalid = 1'b0;
        chk("t4_clear", bus.load_pending, 64'd0);
        chk("fifo_order_head", bus.out_address, 64'h102);
        drain();

        // Load to x0
        req(1'b0, 32'h300, 64'd0, 2'd2, 5'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("x0_enq", bus.empty, 1'b0);
        chk("x0_pending", bus.load_pending, 64'd0);
        drain();

        // Fill three entries, then reset mid-operation
        req(1'b1, 32'h40, 64'h11, 2'd3, 5'd0);
        tick();
        req(1'b0, 32'h48, 64'd0, 2'd3, 5'd6);
        tick();
        req(1'b1, 32'h50, 64'h22, 2'd3, 5'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("fill_pending", bus.load_pending, 64'h40);
        chk("fill_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst2_empty", bus.empty, 1'b1);
        chk("rst2_out_valid", bus.out_valid, 1'b0);
        chk("rst2_pending", bus.load_pending, 64'd0);
        chk("rst2_in_ready", bus.in_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
